// File: rtl/iot_event_encoder.sv
// Device connect/disconnect event encoder: serialises changes in dev_status
// into one-cycle on_off strobes, round-robin, with a configurable idle gap.
module iot_event_encoder #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dev_status,
    input  logic       enable,
    output logic       on_off,
    output logic       change,
    output logic [2:0] dev_id,
    output logic [7:0] expected_count,
    output logic       busy
);

    typedef enum logic [1:0] {
        SCAN,
        EMIT,
        GAP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] reported_q, reported_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] gap_q, gap_d;
    logic       on_off_q, on_off_d;
    logic       change_q, change_d;
    logic [2:0] dev_id_q, dev_id_d;
    logic [7:0] count_q, count_d;

    logic [7:0] pending;
    logic       found;
    logic [2:0] grant_idx;
    logic [2:0] idx;

    assign pending = dev_status ^ reported_q;

    // Round-robin search starting at ptr_q, wrapping 7 -> 0.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && pending[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        reported_d = reported_q;
        ptr_d      = ptr_q;
        gap_d      = gap_q;
        on_off_d   = 1'b0;
        change_d   = change_q;
        dev_id_d   = dev_id_q;
        count_d    = count_q;
        case (state_q)
            SCAN: begin
                if (enable && found) begin
                    state_d               = EMIT;
                    on_off_d              = 1'b1;
                    dev_id_d              = grant_idx;
                    change_d              = dev_status[grant_idx];
                    reported_d[grant_idx] = dev_status[grant_idx];
                    count_d               = dev_status[grant_idx] ? count_q + 8'd1
                                                                  : count_q - 8'd1;
                    ptr_d                 = grant_idx + 3'd1;
                end
            end
            EMIT: begin
                if (GAP_CYCLES == 0) begin
                    state_d = SCAN;
                end else begin
                    state_d = GAP;
                    gap_d   = 4'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = SCAN;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCAN;
            reported_q <= '0;
            ptr_q      <= '0;
            gap_q      <= '0;
            on_off_q   <= 1'b0;
            change_q   <= 1'b0;
            dev_id_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            reported_q <= reported_d;
            ptr_q      <= ptr_d;
            gap_q      <= gap_d;
            on_off_q   <= on_off_d;
            change_q   <= change_d;
            dev_id_q   <= dev_id_d;
            count_q    <= count_d;
        end
    end

    assign on_off         = on_off_q;
    assign change         = change_q;
    assign dev_id         = dev_id_q;
    assign expected_count = count_q;
    assign busy           = |pending;

endmodule

// File: tb/tb_iot_event_encoder.sv
// Directed table-driven bench for iot_event_encoder (GAP_CYCLES = 1).
module tb_iot_event_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dev_status;
    logic       enable;
    logic       on_off;
    logic       change;
    logic [2:0] dev_id;
    logic [7:0] expected_count;
    logic       busy;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    always #5 clk = ~clk;

    iot_event_encoder #(.GAP_CYCLES(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .dev_status     (dev_status),
        .enable         (enable),
        .on_off         (on_off),
        .change         (change),
        .dev_id         (dev_id),
        .expected_count (expected_count),
        .busy           (busy)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] ds;
        logic       on;
        logic       ch;
        logic [2:0] id;
        logic [7:0] cnt;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic e, input logic [7:0] d,
                                input logic o, input logic c, input logic [2:0] i,
                                input logic [7:0] n, input logic b);
        vec_t v;
        v.rst = r; v.en = e; v.ds = d;
        v.on = o; v.ch = c; v.id = i; v.cnt = n; v.bsy = b;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic o, input logic c,
                         input logic [2:0] i, input logic [7:0] n, input logic b);
        n_vec++;
        if (on_off !== o || change !== c || dev_id !== i ||
            expected_count !== n || busy !== b) begin
            n_miss++;
            $display("FAIL %s: got on_off=%b change=%b dev_id=%0d count=%0d busy=%b, want on_off=%b change=%b dev_id=%0d count=%0d busy=%b",
                     name, on_off, change, dev_id, expected_count, busy, o, c, i, n, b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable = 1'b1; dev_status = 8'h00;

        // reset held two cycles, then ten idle cycles
        add(1,1,8'h00, 0,0,0,0,0);
        add(1,1,8'h00, 0,0,0,0,0);
        for (int k = 0; k < 10; k++) add(0,1,8'h00, 0,0,0,0,0);
        // 0x00 -> 0x05: dev 0 then dev 2, one GAP cycle plus one SCAN cycle apart
        add(0,1,8'h05, 1,1,0,1,1);
        add(0,1,8'h05, 0,1,0,1,1);
        add(0,1,8'h05, 0,1,0,1,1);
        add(0,1,8'h05, 1,1,2,2,0);
        add(0,1,8'h05, 0,1,2,2,0);
        add(0,1,8'h05, 0,1,2,2,0);
        // 0x05 -> 0x04: single disconnect of dev 0 (ptr=3 wraps to 0)
        add(0,1,8'h04, 1,0,0,1,0);
        add(0,1,8'h04, 0,0,0,1,0);
        add(0,1,8'h04, 0,0,0,1,0);
        // disconnect dev 2 to leave ptr=3
        add(0,1,8'h00, 1,0,2,0,0);
        add(0,1,8'h00, 0,0,2,0,0);
        add(0,1,8'h00, 0,0,2,0,0);
        // fairness: bits 7 and 1 together with ptr=3 -> 7 first, then 1
        add(0,1,8'h82, 1,1,7,1,1);
        add(0,1,8'h82, 0,1,7,1,1);
        add(0,1,8'h82, 0,1,7,1,1);
        add(0,1,8'h82, 1,1,1,2,0);
        add(0,1,8'h82, 0,1,1,2,0);
        add(0,1,8'h82, 0,1,1,2,0);
        // enable low blocks grant on pending bit 4
        add(0,0,8'h92, 0,1,1,2,1);
        add(0,0,8'h92, 0,1,1,2,1);
        add(0,1,8'h92, 1,1,4,3,0);
        // enable dropped during EMIT/GAP does not abort
        add(0,0,8'h92, 0,1,4,3,0);
        add(0,0,8'h92, 0,1,4,3,0);
        // glitch on dev 0 that returns before grant: no event
        add(0,0,8'h93, 0,1,4,3,1);
        add(0,0,8'h92, 0,1,4,3,0);
        add(0,1,8'h92, 0,1,4,3,0);
        // reset, then build count to 3 with dev_status=0x07
        add(1,1,8'h00, 0,0,0,0,0);
        add(0,1,8'h07, 1,1,0,1,1);
        add(0,1,8'h07, 0,1,0,1,1);
        add(0,1,8'h07, 0,1,0,1,1);
        add(0,1,8'h07, 1,1,1,2,1);
        add(0,1,8'h07, 0,1,1,2,1);
        add(0,1,8'h07, 0,1,1,2,1);
        add(0,1,8'h07, 1,1,2,3,0);
        add(0,1,8'h07, 0,1,2,3,0);
        // reset during GAP: outputs clear, devices re-reported as connects
        add(1,1,8'h07, 0,0,0,0,1);
        add(0,1,8'h07, 1,1,0,1,1);
        add(0,1,8'h07, 0,1,0,1,1);
        add(0,1,8'h07, 0,1,0,1,1);
        add(0,1,8'h07, 1,1,1,2,1);
        add(0,1,8'h07, 0,1,1,2,1);
        add(0,1,8'h07, 0,1,1,2,1);
        add(0,1,8'h07, 1,1,2,3,0);
        add(0,1,8'h07, 0,1,2,3,0);
        add(0,1,8'h07, 0,1,2,3,0);

        for (int k = 0; k < vecs.size(); k++) begin
            rst        = vecs[k].rst;
            enable     = vecs[k].en;
            dev_status = vecs[k].ds;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k), vecs[k].on, vecs[k].ch, vecs[k].id,
                  vecs[k].cnt, vecs[k].bsy);
        end

        // all eight connected: remaining devices 3..7 reported in order, count reaches 8
        rst = 1'b0; enable = 1'b1; dev_status = 8'hFF;
        for (int d = 3; d < 8; d++) begin
            int unsigned waited;
            waited = 0;
            do begin
                @(posedge clk);
                #1;
                waited++;
            end while (!on_off && waited < 8);
            if (!on_off) begin
                n_vec++;
                n_miss++;
                $display("FAIL all_on_wait%0d: got no on_off pulse within 8 cycles, want pulse", d);
            end else begin
                check($sformatf("all_on_dev%0d", d), 1'b1, 1'b1, 3'(d), 8'(d + 1),
                      (d == 7) ? 1'b0 : 1'b1);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("all_on_final", 1'b0, 1'b1, 3'd7, 8'd8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/iot_event_encoder.md
IOT_EVENT_ENCODER -- requirements
Module: iot_event_encoder

Interface
REQ-001 Parameter GAP_CYCLES, default 1, number of idle cycles (on_off low) forced after each event; legal range 0-15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 dev_status  input  8  live connection state of devices 0-7; 1 = connected.
REQ-005 enable  input  1  permits new event grants when high.
REQ-006 on_off  output  1  event strobe to the monitor; high for exactly one cycle per event.
REQ-007 change  output  1  event direction, valid while on_off high: 1 = connect (increment), 0 = disconnect (decrement).
REQ-008 dev_id  output  3  index of the device the current event reports.
REQ-009 expected_count  output  8  number of devices currently reported as connected; the count the monitor shall hold.
REQ-010 busy  output  1  combinational; high when dev_status differs from the reported state in any bit.

Function
REQ-011 The block SHALL hold a register reported[7:0] of last-reported device states; pending = dev_status XOR reported.
REQ-012 FSM states SHALL be SCAN, EMIT and GAP.
REQ-013 SCAN -> EMIT SHALL occur when enable=1 and pending!=0; otherwise the FSM stays in SCAN.
REQ-014 The grant SHALL be round-robin: search pending from index ptr upward, wrapping 7->0; the first set bit i wins.
REQ-015 On the grant edge the block SHALL register on_off=1, dev_id=i and change=dev_status[i], and set reported[i]=dev_status[i].
REQ-016 On the same edge, expected_count SHALL increment when change=1 and decrement when change=0.
REQ-017 On the same edge, ptr SHALL become (i+1) mod 8.
REQ-018 Latency: on_off SHALL rise on the first clock edge at which the difference is visible in SCAN with enable=1.
REQ-019 EMIT SHALL last one cycle; on_off returns to 0 on the next edge.
REQ-020 EMIT -> GAP when GAP_CYCLES>0; GAP lasts exactly GAP_CYCLES cycles, then the FSM returns to SCAN.
REQ-021 EMIT -> SCAN directly when GAP_CYCLES=0, giving at most one event per two cycles.
REQ-022 dev_id and change SHALL hold their last values while on_off is low.
REQ-023 Deasserting enable during EMIT or GAP SHALL NOT abort the sequence; it only blocks the next grant.
REQ-024 A device that toggles and returns before being granted SHALL produce no event.
REQ-025 A device that changes again after its grant SHALL produce a further event on a later SCAN.
REQ-026 expected_count SHALL always equal popcount(reported), range 0-8; no wrap, underflow or overflow is possible.
REQ-027 Simultaneous pending bits SHALL be served one per event in round-robin order; none is dropped.

Reset
REQ-028 When rst=1 at a clock edge, the following SHALL clear on that edge: on_off=0, change=0, dev_id=0, expected_count=0, reported=0, ptr=0, gap counter=0, state=SCAN.
REQ-029 Reset SHALL override any in-progress EMIT or GAP; no event is emitted in the reset cycle.
REQ-030 After rst deasserts, devices still connected SHALL be reported as fresh connect events, consistent with a monitor reset to 0.

Verification
REQ-031 rst held 2 cycles, dev_status=0x00, enable=1 -> all outputs 0, busy=0, no on_off pulse for 10 cycles.
REQ-032 GAP_CYCLES=1, dev_status 0x00->0x05 -> event (dev_id=0, change=1), 1 idle cycle, event (dev_id=2, change=1); expected_count 2, busy=0.
REQ-033 Then dev_status 0x05->0x04 -> single event (dev_id=0, change=0); expected_count 1.
REQ-034 Fairness: with ptr=3, bits 1 and 7 set simultaneously -> dev_id 7 first, then dev_id 1.
REQ-035 enable=0 with pending 0x10 -> on_off stays 0, busy=1; enable=1 -> on_off=1 with dev_id=4 on the next edge.
REQ-036 rst pulsed during GAP with expected_count=3 and dev_status=0x07 -> outputs zero next cycle; then three connect events (dev_id 0, 1, 2) and expected_count 3; all 8 connected -> expected_count 8.
